// File: rtl/spike_aer_encoder_if.sv
// AER event stream between the spike encoder and its consumer.
// Master drives a valid event (address + timestamp); slave answers with ready.
interface spike_aer_encoder_if #(
  parameter int ADDR_W = 3,
  parameter int TS_W   = 8
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [TS_W-1:0]   ts;

  modport master (output valid, output addr, output ts, input ready);
  modport slave  (input valid, input addr, input ts, output ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// Serialises per-neuron spike pulses into timestamped AER events through a show-ahead FIFO.
// Spikes that collide with a still-pending spike of the same neuron are counted as drops.
module spike_aer_encoder #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = 3,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_NEURONS-1:0]        spike_in,
  input  logic                          tick,
  input  logic                          clear_overflow,
  spike_aer_encoder_if.master           aer,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DCW   = $clog2(NUM_NEURONS) + 1;
  localparam int EW    = ADDR_W + TS_W;

  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [NUM_NEURONS-1:0] pushed, dropped;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic [CNT_W:0]         drop_sum;
  logic [DCW-1:0]         drop_num;
  logic [ADDR_W-1:0]      push_idx;
  logic                   pop, push, can_accept;

  // Lowest pending index wins the single push slot of the cycle.
  always_comb begin
    push_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) push_idx = ADDR_W'(i);
    end
  end

  assign aer.valid  = (count_q != '0);
  assign pop        = aer.valid & aer.ready;
  assign can_accept = (count_q < (PTR_W + 1)'(FIFO_DEPTH)) | pop;
  assign push       = (|pending_q) & can_accept;
  assign pushed     = push ? (NUM_NEURONS'(1) << push_idx) : '0;
  assign dropped    = spike_in & pending_q & ~pushed;
  assign pending_d  = (pending_q & ~pushed) | spike_in;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      drop_num = drop_num + DCW'(dropped[i]);
    end
  end

  // A clear in the same cycle as a drop restarts the tally from this cycle's drops.
  always_comb begin
    drop_sum   = (clear_overflow ? '0 : {1'b0, drop_q}) + (CNT_W + 1)'(drop_num);
    drop_d     = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    overflow_d = (overflow_q & ~clear_overflow) | (|dropped);
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ts_d     = tick ? ts_q + TS_W'(1) : ts_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      ts_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      pending_q  <= pending_d;
      ts_q       <= ts_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_idx, ts_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign aer.addr   = aer.valid ? head[EW-1:TS_W] : '0;
  assign aer.ts     = aer.valid ? head[TS_W-1:0] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder: directed vector table, corner-case sequences,
// and randomized traffic compared against a queue-based event model.
module tb_spike_aer_encoder;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] spike_in = '0;
  logic       tick = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  spike_aer_encoder_if #(.ADDR_W(3), .TS_W(8)) aer ();

  spike_aer_encoder #(
    .NUM_NEURONS(8), .ADDR_W(3), .TS_W(8), .FIFO_DEPTH(16), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .tick(tick),
    .clear_overflow(clear_overflow), .aer(aer), .fifo_count(fifo_count),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: event queue, per-neuron pending flags, integer counters.
  typedef struct { int a; int t; } ev_t;
  ev_t evq[$];
  bit  mPend[8];
  int  mTs = 0;
  int  mDrops = 0;
  bit  mOvf = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evq.delete();
      foreach (mPend[i]) mPend[i] = 0;
      mTs = 0; mDrops = 0; mOvf = 0;
    end else begin
      bit popNow, accept;
      int pushIdx, nd;
      popNow = (evq.size() > 0) && aer.ready;
      accept = (evq.size() < 16) || popNow;
      pushIdx = -1;
      if (accept) begin
        for (int i = 0; i < 8; i++) begin
          if (mPend[i] && pushIdx < 0) pushIdx = i;
        end
      end
      nd = 0;
      for (int i = 0; i < 8; i++) begin
        if (spike_in[i] && mPend[i] && i != pushIdx) nd++;
      end
      if (popNow) void'(evq.pop_front());
      if (pushIdx >= 0) evq.push_back('{a: pushIdx, t: mTs});
      for (int i = 0; i < 8; i++) mPend[i] = (mPend[i] && i != pushIdx) || spike_in[i];
      if (clear_overflow) begin
        mDrops = (nd > 255) ? 255 : nd;
        mOvf = (nd > 0);
      end else begin
        mDrops = (mDrops + nd > 255) ? 255 : mDrops + nd;
        mOvf = mOvf || (nd > 0);
      end
      if (tick) mTs = (mTs + 1) % 256;
    end
  end

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    int sz;
    sz = evq.size();
    checkVal({name, "_valid"}, int'(aer.valid), (sz > 0) ? 1 : 0);
    checkVal({name, "_addr"}, int'(aer.addr), (sz > 0) ? evq[0].a : 0);
    checkVal({name, "_ts"}, int'(aer.ts), (sz > 0) ? evq[0].t : 0);
    checkVal({name, "_count"}, int'(fifo_count), sz);
    checkVal({name, "_drop"}, int'(drop_count), mDrops);
    checkVal({name, "_ovf"}, int'(overflow), int'(mOvf));
  endtask

  task automatic applyStimulus(input logic [7:0] sp, input logic tk, input logic rdy, input logic clr);
    @(negedge clk);
    spike_in = sp;
    tick = tk;
    aer.ready = rdy;
    clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic fillFifo();
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
      checkOutput(name);
    end
  endtask

  typedef struct {
    logic [7:0] spike;
    logic       tk;
    logic       rdy;
    logic       expValid;
    logic [2:0] expAddr;
    logic [7:0] expTs;
    logic [4:0] expCount;
    logic [7:0] expDrop;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int tsBefore;

    vecs[0]  = '{8'h04, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 5'd0, 8'd0};
    vecs[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'd0, 5'd1, 8'd0};
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 5'd0, 8'd0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 5'd0, 8'd0};
    vecs[4]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'd0, 5'd1, 8'd0};
    vecs[5]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd6, 8'd0, 5'd1, 8'd0};
    vecs[6]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'd0, 5'd1, 8'd0};
    vecs[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 5'd0, 8'd0};
    vecs[8]  = '{8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 5'd0, 8'd0};
    vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'd1, 5'd1, 8'd0};
    vecs[10] = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'd1, 5'd1, 8'd0};
    vecs[11] = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'd1, 5'd2, 8'd0};
    vecs[12] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'd1, 5'd2, 8'd0};
    vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'd1, 5'd1, 8'd0};
    vecs[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 5'd0, 8'd0};

    aer.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_valid", int'(aer.valid), 0);
    checkVal("rst_addr", int'(aer.addr), 0);
    checkVal("rst_ts", int'(aer.ts), 0);
    checkVal("rst_count", int'(fifo_count), 0);
    checkVal("rst_ovf", int'(overflow), 0);
    checkVal("rst_drop", int'(drop_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].spike, vecs[i].tk, vecs[i].rdy, 1'b0);
      checkVal($sformatf("vec%0d_valid", i), int'(aer.valid), int'(vecs[i].expValid));
      checkVal($sformatf("vec%0d_addr", i), int'(aer.addr), int'(vecs[i].expAddr));
      checkVal($sformatf("vec%0d_ts", i), int'(aer.ts), int'(vecs[i].expTs));
      checkVal($sformatf("vec%0d_count", i), int'(fifo_count), int'(vecs[i].expCount));
      checkVal($sformatf("vec%0d_drop", i), int'(drop_count), int'(vecs[i].expDrop));
    end

    // Single spike stamped with a timestamp of 5.
    repeat (4) applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h04, 1'b0, 1'b1, 1'b0);
    checkVal("single_early", int'(aer.valid), 0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkVal("single_addr", int'(aer.addr), 2);
    checkVal("single_ts", int'(aer.ts), 5);
    drain("single", 2);
    checkVal("single_empty", int'(fifo_count), 0);

    // Full FIFO holds further spikes as pending without dropping them.
    fillFifo();
    checkVal("full_count", int'(fifo_count), 16);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkVal("held_count", int'(fifo_count), 16);
    checkVal("held_drop", int'(drop_count), 0);
    checkVal("held_ovf", int'(overflow), 0);
    checkOutput("held");
    drain("bp_drain", 20);

    // Drops, clear, and clear colliding with a drop.
    fillFifo();
    checkVal("refill_count", int'(fifo_count), 16);
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
    checkVal("drop_first", int'(drop_count), 0);
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
    checkVal("drop_count", int'(drop_count), 1);
    checkVal("drop_ovf", int'(overflow), 1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkVal("clr_count", int'(drop_count), 0);
    checkVal("clr_ovf", int'(overflow), 0);
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b1);
    checkVal("clrdrop_count", int'(drop_count), 1);
    checkVal("clrdrop_ovf", int'(overflow), 1);
    drain("drop_drain", 20);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 9) < 4),
                    1'($urandom_range(0, 39) == 0));
      checkOutput("rand");
    end
    drain("rand_drain", 30);

    // Timestamp wrap, then a push on a tick edge keeps the pre-increment stamp.
    tsBefore = mTs;
    repeat (256) applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkVal("wrap_addr", int'(aer.addr), 1);
    checkVal("wrap_ts", int'(aer.ts), tsBefore);
    checkOutput("wrap");

    // Asynchronous reset with a half-full FIFO.
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkVal("half_count", int'(fifo_count), 9);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkVal("arst_valid", int'(aer.valid), 0);
    checkVal("arst_count", int'(fifo_count), 0);
    checkVal("arst_addr", int'(aer.addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    drain("post_rst", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
